// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch unit: single-outstanding AXI-lite read master that fetches one word
// per writeback-supplied PC, hands it to decode, counts completions and flags bus hangs.
module ifu_axi_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    output logic [31:0] o_araddr,
    output logic        o_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic        i_rvalid,
    output logic        o_rready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    input  logic [31:0] i_npc,
    input  logic        i_npc_valid,
    output logic [31:0] o_fetch_cnt,
    output logic        o_bus_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    localparam int unsigned        WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_arvalid_nxt;
    logic              w_rready_nxt;
    logic              w_inst_valid_nxt;
    logic              w_in_bus;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic [31:0]       r_fetch_cnt;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_inst_valid;
    logic              r_bus_err;
    logic [WDOG_W-1:0] r_wdog;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; handshake outputs are registered from the state being entered
    always_comb begin
        w_state_nxt      = r_state;
        w_arvalid_nxt    = 1'b0;
        w_rready_nxt     = 1'b0;
        w_inst_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_AR;
            S_AR:    if (i_arready)    w_state_nxt = S_R;
            S_R:     if (i_rvalid)     w_state_nxt = S_OUT;
            S_OUT:   if (i_inst_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (i_npc_valid)  w_state_nxt = S_AR;
            default: w_state_nxt = S_IDLE;
        endcase
        w_arvalid_nxt    = (w_state_nxt == S_AR);
        w_rready_nxt     = (w_state_nxt == S_R);
        w_inst_valid_nxt = (w_state_nxt == S_OUT);
    end

    assign w_in_bus = (r_state == S_AR) || (r_state == S_R);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_fetch_cnt  <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_bus_err    <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            if ((r_state == S_WAIT) && i_npc_valid) begin
                r_pc <= i_npc;
            end
            if ((r_state == S_R) && i_rvalid) begin
                r_inst <= i_rdata;
            end
            if ((r_state == S_OUT) && i_inst_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            // Watchdog saturates at its limit; the error flag stays until reset
            if (w_in_bus) begin
                if (r_wdog == WDOG_LAST) begin
                    r_bus_err <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + WDOG_W'(1);
                end
            end
            if (w_state_nxt == S_OUT) begin
                r_wdog <= '0;
            end
        end
    end

    assign o_araddr     = r_pc;
    assign o_arvalid    = r_arvalid;
    assign o_rready     = r_rready;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bus_err    = r_bus_err;

`ifndef SYNTHESIS
    // Bus protocol checks; a stray npc pulse is reported but otherwise harmless
    a_ar_align: assert property (@(posedge aclk) disable iff (areset)
        r_arvalid |-> (r_pc[1:0] == 2'b00))
        else $error("araddr misaligned while arvalid");
    a_ar_hold: assert property (@(posedge aclk) disable iff (areset)
        (r_arvalid && !i_arready) |=> (r_arvalid && $stable(r_pc)))
        else $error("arvalid dropped or araddr moved before arready");
    a_npc_drop: assert property (@(posedge aclk) disable iff (areset)
        i_npc_valid |-> (r_state == S_WAIT))
        else $warning("npc_valid outside S_WAIT dropped");
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Drives randomised fetch transactions (stall lengths, don't-care input noise) and compares
// the fetch unit every cycle against a transaction-timeline model of the expected waveforms.
module tb_ifu_axi_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned TIMEOUT  = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] i_npc;
    logic        i_npc_valid;
    logic [31:0] o_fetch_cnt;
    logic        o_bus_err;

    ifu_axi_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .o_araddr    (o_araddr),
        .o_arvalid   (o_arvalid),
        .i_arready   (i_arready),
        .i_rdata     (i_rdata),
        .i_rvalid    (i_rvalid),
        .o_rready    (o_rready),
        .o_inst      (o_inst),
        .o_inst_pc   (o_inst_pc),
        .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready),
        .i_npc       (i_npc),
        .i_npc_valid (i_npc_valid),
        .o_fetch_cnt (o_fetch_cnt),
        .o_bus_err   (o_bus_err)
    );

    always #5 aclk = ~aclk;

    // Model state: what the outputs must read during the current cycle
    logic [31:0] cur_pc;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;
    logic        m_err;
    logic        exp_av;
    logic        exp_rr;
    logic        exp_iv;
    int          bus_cyc;
    bit          chk_en;
    int          total;
    int          bad;
    int          ar_hs_seen;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic rand_inputs();
        i_arready    = 1'($urandom);
        i_rvalid     = 1'($urandom);
        i_rdata      = $urandom;
        i_inst_ready = 1'($urandom);
        i_npc        = $urandom;
        i_npc_valid  = 1'b0;
    endtask

    task automatic set_exp(input logic av, input logic rr, input logic iv);
        exp_av = av;
        exp_rr = rr;
        exp_iv = iv;
    endtask

    // One cycle spent with the request on the bus counts toward the hang limit
    task automatic bus_step();
        bus_cyc++;
        if (bus_cyc >= int'(TIMEOUT)) m_err = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rand_inputs();
        areset = 1'b1;
        chk_en = 1'b0;
        tick();
        cur_pc  = RESET_PC;
        m_inst  = '0;
        m_cnt   = '0;
        m_err   = 1'b0;
        bus_cyc = 0;
        set_exp(1'b0, 1'b0, 1'b0);
        chk_en  = 1'b1;
        for (int k = 1; k < n; k++) begin
            rand_inputs();
            tick();
        end
        // release cycle is the one idle bubble before the first request
        rand_inputs();
        areset = 1'b0;
        tick();
    endtask

    // Whole fetch of address a: address stall, data stall, decode stall, gap before npc.
    task automatic fetch(input logic [31:0] a, input int ar_d, input int r_d, input int out_d,
                         input int wait_d, input logic [31:0] nxt, input bit abort_r,
                         input bit npc_in_r);
        for (int k = 0; k <= ar_d; k++) begin
            rand_inputs();
            i_arready = (k == ar_d);
            set_exp(1'b1, 1'b0, 1'b0);
            tick();
            bus_step();
        end
        for (int k = 0; k <= r_d; k++) begin
            rand_inputs();
            i_rvalid = !abort_r && (k == r_d);
            if (i_rvalid) i_rdata = mem(a);
            if (npc_in_r && (k == 0)) begin
                i_npc_valid = 1'b1;
                i_npc       = a + 32'h40;
            end
            set_exp(1'b0, 1'b1, 1'b0);
            tick();
            bus_step();
        end
        if (abort_r) return;
        m_inst  = mem(a);
        bus_cyc = 0;
        for (int k = 0; k <= out_d; k++) begin
            rand_inputs();
            i_inst_ready = (k == out_d);
            set_exp(1'b0, 1'b0, 1'b1);
            tick();
        end
        m_cnt = m_cnt + 32'd1;
        for (int k = 0; k <= wait_d; k++) begin
            rand_inputs();
            i_npc_valid = (k == wait_d);
            if (i_npc_valid) i_npc = nxt;
            set_exp(1'b0, 1'b0, 1'b0);
            tick();
        end
        cur_pc = nxt;
    endtask

    // Per-cycle comparison, sampled mid-cycle
    initial begin
        forever begin
            @(negedge aclk);
            if (chk_en) begin
                check("arvalid",    32'(o_arvalid),    32'(exp_av));
                check("rready",     32'(o_rready),     32'(exp_rr));
                check("inst_valid", 32'(o_inst_valid), 32'(exp_iv));
                check("araddr",     o_araddr,          cur_pc);
                check("inst_pc",    o_inst_pc,         cur_pc);
                check("inst",       o_inst,            m_inst);
                check("fetch_cnt",  o_fetch_cnt,       m_cnt);
                check("bus_err",    32'(o_bus_err),    32'(m_err));
            end
            if (o_arvalid && i_arready && !areset) ar_hs_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end want end at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [31:0] nxt;
        total = 0;
        bad = 0;
        ar_hs_seen = 0;
        chk_en = 1'b0;
        areset = 1'b1;
        i_arready = 1'b0;
        i_rvalid = 1'b0;
        i_rdata = '0;
        i_inst_ready = 1'b0;
        i_npc = '0;
        i_npc_valid = 1'b0;
        cur_pc = RESET_PC;
        m_inst = '0;
        m_cnt = '0;
        m_err = 1'b0;
        bus_cyc = 0;
        set_exp(1'b0, 1'b0, 1'b0);

        do_reset(3);
        check("first_arvalid", 32'(o_arvalid), 32'd1);
        check("first_araddr", o_araddr, 32'h8000_0000);
        fetch(RESET_PC, 0, 0, 0, 0, 32'h8000_0010, 1'b0, 1'b0);
        check("first_inst", o_inst, 32'h5EAD_BEEF);
        check("first_cnt", o_fetch_cnt, 32'd1);
        check("npc_araddr", o_araddr, 32'h8000_0010);

        // address channel stalled five cycles
        fetch(32'h8000_0010, 5, 0, 0, 1, 32'h8000_0020, 1'b0, 1'b0);
        check("ar_hs_count", 32'(ar_hs_seen), 32'd2);
        check("stall_bus_err", 32'(o_bus_err), 32'd0);

        // decode stalled three cycles, slave with 2-cycle read data
        fetch(32'h8000_0020, 0, 1, 3, 2, 32'h8000_0100, 1'b0, 1'b0);
        check("cnt_after_stall", o_fetch_cnt, 32'd3);

        // stray npc pulse during the data phase
        fetch(32'h8000_0100, 1, 2, 0, 0, 32'h8000_0200, 1'b0, 1'b1);
        check("npc_drop_pc", o_araddr, 32'h8000_0200);

        for (int i = 0; i < 60; i++) begin
            nxt = $urandom & 32'hFFFF_FFFC;
            fetch(cur_pc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), nxt, 1'b0, 1'b0);
        end

        // watchdog edge: 7 bus cycles is fine, 8 trips it
        fetch(cur_pc, 3, 2, 0, 0, 32'h8000_0300, 1'b0, 1'b0);
        check("wdog_7_cycles", 32'(o_bus_err), 32'd0);
        fetch(cur_pc, 3, 3, 0, 0, 32'h8000_0304, 1'b0, 1'b0);
        check("wdog_8_cycles", 32'(o_bus_err), 32'd1);
        do_reset(2);
        check("reset_bus_err", 32'(o_bus_err), 32'd0);
        check("reset_cnt", o_fetch_cnt, 32'd0);

        // reset while waiting on read data, then refetch from the reset PC
        fetch(RESET_PC, 0, 3, 0, 0, 32'h0, 1'b1, 1'b0);
        do_reset(1);
        check("midr_araddr", o_araddr, 32'h8000_0000);
        check("midr_cnt", o_fetch_cnt, 32'd0);
        fetch(RESET_PC, 0, 0, 0, 0, 32'h8000_0040, 1'b0, 1'b0);
        check("refetch_inst", o_inst, 32'h5EAD_BEEF);
        check("refetch_cnt", o_fetch_cnt, 32'd1);

        // slave never returns data: error sets and sticks until reset
        fetch(32'h8000_0040, 2, 12, 0, 0, 32'h0, 1'b1, 1'b0);
        check("hang_bus_err", 32'(o_bus_err), 32'd1);
        check("hang_rready", 32'(o_rready), 32'd1);
        do_reset(1);
        check("hang_cleared", 32'(o_bus_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
